thermo_pattern_sequencer: RTL and testbench
===========================================

Name: thermo_pattern_sequencer

Overview:
Parametrised code generator feeding the thermometer/non-overlap DAC driver chain. It replaces the fixed 8-bit up/down sweep and 8-bit shift loader with a configurable engine:
- Four modes: static code, bounded triangle sweep with programmable step and limits, sawtooth, and a framed serial pattern load with commit handshake.
- A rate prescaler sets the update rate.
- Its registered thermometer output drives non_overlap directly.

Parameters:
CODE_W, 8, code width in bits.
OUT_W, 2**CODE_W, thermometer output width; must be a multiple of LOAD_W.
LOAD_W, 8, serial load beat width.
DIV_W, 8, prescaler divisor width.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  reset, synchronous, active-high.
en  input  1  prescaler/sequencer enable.
mode  input  2  0=STATIC, 1=TRIANGLE, 2=SAW, 3=PATTERN.
div  input  DIV_W  tick every div+1 enabled cycles.
step  input  CODE_W  code increment per tick.
lo_lim  input  CODE_W  lower sweep limit.
hi_lim  input  CODE_W  upper sweep limit.
static_code  input  CODE_W  code used in STATIC.
ld_data  input  LOAD_W  serial pattern beat.
ld_valid  input  1  beat valid.
ld_ready  output  1  beat accepted when ld_valid&&ld_ready.
commit  input  1  copy the shadow frame to the active pattern.
code_out  output  CODE_W  current code.
dir_up  output  1  triangle direction.
edge_pulse  output  1  one-cycle pulse on a triangle turn or saw wrap.
thermo_out  output  OUT_W  registered driver pattern.

Behaviour:
Reset (rst=1 at a clk edge), all registers cleared except dir_up:
- code_out=0, dir_up=1, edge_pulse=0, thermo_out=0.
- Prescaler count, shadow, pattern and beat count all 0.
- ld_ready=1.
- Reset mid-sweep or mid-frame discards all state; there is no partial commit.

Prescaler:
- Counts only while en=1.
- tick=1 when count==div; count then returns to 0.
- div=0 gives a tick every enabled cycle.
- en=0 freezes the count; it does not clear it.

Sweep arithmetic:
- Computed at CODE_W+1 bits; there is no silent wrap.
- step=0 holds the code.

Mode behaviour, evaluated on tick:
- STATIC: code<=static_code.
- TRIANGLE, dir_up=1: if code+step>=hi_lim then code<=hi_lim, dir_up<=0, edge_pulse; else code<=code+step.
- TRIANGLE, dir_up=0: if code<lo_lim+step then code<=lo_lim, dir_up<=1, edge_pulse; else code<=code-step.
- SAW: if code+step>hi_lim then code<=lo_lim, edge_pulse; else code<=code+step. dir_up is held.
- Mode 1/2 entered with code outside [lo_lim,hi_lim]: the first tick loads lo_lim (TRIANGLE also sets dir_up=1). No edge_pulse.
- lo_lim>=hi_lim in mode 1/2: every tick loads lo_lim; no edge_pulse.
- PATTERN: code is held.

Pattern load (active in every mode):
- FRAMES = OUT_W/LOAD_W.
- Accepted beat: shadow<={shadow[OUT_W-LOAD_W-1:0], ld_data} (first beat ends in the MSBs); beat count increments.
- ld_ready=0 when beat count==FRAMES.
- commit: pattern<=shadow and beat count<=0, whatever the fill level.
- commit together with an accepted beat: pattern takes the shadow value before the beat. The beat is shifted in and the beat count becomes 1.

Output, registered one cycle after code/pattern:
- thermo_out bit i = (i < code_out) in modes 0-2. Bit OUT_W-1 is therefore never set.
- thermo_out = pattern in mode 3.
- A mode change takes effect on thermo_out 1 cycle later.
- Latency from tick to thermo_out: 1 cycle for code_out, 2 cycles for thermo_out.
- edge_pulse is registered and aligned with code_out.

Decomposition:
- Package thermo_seq_pkg holds:
  - mode_e enum (MODE_STATIC, MODE_TRIANGLE, MODE_SAW, MODE_PATTERN);
  - the FRAMES-derivation function;
  - the default width constants.
- Reuse the existing thermometer_encoder (IN_WIDTH=CODE_W, OUT_WIDTH=OUT_W) for modes 0-2.
- Natural sub-module: thermo_pattern_loader, containing the shadow register, beat counter, ld_ready, commit and the pattern register.

Test Plan:
1. Reset and STATIC: rst=1 for 2 cycles, then mode=0, static_code=37, div=0, en=1 -> code_out=37 after 1 cycle; thermo_out has bits[36:0]=1, rest 0, one cycle later. Reset values checked during rst.
2. TRIANGLE: lo=10, hi=20, step=4, div=0 from code 10 -> sequence 14,18,20(edge_pulse, dir_up=0),16,12,10(edge_pulse, dir_up=1),14.
3. SAW with prescaler: lo=0, hi=255, step=100, div=2 -> code changes every 3rd cycle: 100,200,0(edge_pulse),100; en=0 for 5 cycles freezes code and prescaler.
4. Boundaries:
   - step=0 holds the code.
   - lo=hi=50 from code 0: first tick gives code=50 with no edge_pulse.
   - hi=255, step=255 from code 1: clamps to 255, no overflow.
5. PATTERN: 32 beats 0x00..0x1F, then ld_ready=0 on the 33rd offer. commit -> thermo_out[255:248]=0x00, thermo_out[7:0]=0x1F, 2 cycles later; ld_ready=1 again.
6. Commit collisions:
   - commit with 3 beats loaded -> pattern upper bits zero-filled per the shift rule.
   - commit together with an accepted beat -> pattern excludes that beat; beat count=1.
   - rst asserted mid-frame -> pattern and thermo_out=0.

Source files
------------

// File: rtl/thermo_seq_pkg.sv
// Shared types and constants for the thermometer pattern sequencer.
package thermo_seq_pkg;

   localparam int unsigned CODE_W_DEF = 8;
   localparam int unsigned LOAD_W_DEF = 8;
   localparam int unsigned DIV_W_DEF  = 8;

   typedef enum logic [1:0] {
      MODE_STATIC   = 2'd0,
      MODE_TRIANGLE = 2'd1,
      MODE_SAW      = 2'd2,
      MODE_PATTERN  = 2'd3
   } mode_e;

   // Number of serial beats that make up one full output frame.
   function automatic int unsigned frames_of(input int unsigned out_w, input int unsigned load_w);
      return out_w / load_w;
   endfunction

endpackage

// File: rtl/thermo_pattern_loader.sv
// Framed serial pattern loader: shadow shift register, beat counter and committed pattern.
module thermo_pattern_loader
   import thermo_seq_pkg::*;
#(
   parameter int unsigned OUT_W  = 256,
   parameter int unsigned LOAD_W = LOAD_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [LOAD_W-1:0] i_ld_data,
   input  logic              i_ld_valid,
   input  logic              i_commit,
   output logic              o_ld_ready,
   output logic [OUT_W-1:0]  o_pattern
);

   localparam int unsigned FRAMES = frames_of(OUT_W, LOAD_W);
   localparam int unsigned CNT_W  = $clog2(FRAMES + 1);
   localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);

   logic [OUT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_beat_cnt;
   logic             w_accept;

   assign o_ld_ready = (r_beat_cnt != FRAMES_C);
   assign w_accept   = i_ld_valid && o_ld_ready;

   // Commit captures the shadow as it stood before any beat accepted on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shadow   <= '0;
         r_beat_cnt <= '0;
         o_pattern  <= '0;
      end else begin
         if (w_accept) begin
            r_shadow <= {r_shadow[OUT_W-LOAD_W-1:0], i_ld_data};
         end
         if (i_commit) begin
            o_pattern  <= r_shadow;
            r_beat_cnt <= w_accept ? CNT_W'(1) : '0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/thermometer_encoder.sv
// Binary code to thermometer code: bit i is set when i < code.
module thermometer_encoder #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH = 256
) (
   input  logic [IN_WIDTH-1:0]  i_code,
   output logic [OUT_WIDTH-1:0] o_thermo
);

   always_comb begin
      o_thermo = '0;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
         o_thermo[i] = (i < 32'(i_code));
      end
   end

endmodule

// File: rtl/thermo_pattern_sequencer.sv
// Configurable code generator (static/triangle/saw/pattern) with rate prescaler
// and a registered thermometer output for the non-overlap DAC driver.
module thermo_pattern_sequencer
   import thermo_seq_pkg::*;
#(
   parameter int unsigned CODE_W = CODE_W_DEF,
   parameter int unsigned OUT_W  = 2**CODE_W,
   parameter int unsigned LOAD_W = LOAD_W_DEF,
   parameter int unsigned DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  div,
   input  logic [CODE_W-1:0] step,
   input  logic [CODE_W-1:0] lo_lim,
   input  logic [CODE_W-1:0] hi_lim,
   input  logic [CODE_W-1:0] static_code,
   input  logic [LOAD_W-1:0] ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              commit,
   output logic [CODE_W-1:0] code_out,
   output logic              dir_up,
   output logic              edge_pulse,
   output logic [OUT_W-1:0]  thermo_out
);

   mode_e             w_mode;
   logic              w_tick;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [CODE_W:0]   w_sum;
   logic [CODE_W:0]   w_lo_step;
   logic              w_in_range;
   logic              w_degenerate;
   logic [OUT_W-1:0]  w_thermo;
   logic [OUT_W-1:0]  w_pattern;

   assign w_mode       = mode_e'(mode);
   assign w_tick       = en && (r_div_cnt == div);
   // One extra bit so limit comparisons never see a wrapped sum.
   assign w_sum        = {1'b0, code_out} + {1'b0, step};
   assign w_lo_step    = {1'b0, lo_lim} + {1'b0, step};
   assign w_in_range   = (code_out >= lo_lim) && (code_out <= hi_lim);
   assign w_degenerate = (lo_lim >= hi_lim);

   thermometer_encoder #(
      .IN_WIDTH  (CODE_W),
      .OUT_WIDTH (OUT_W)
   ) u_enc (
      .i_code   (code_out),
      .o_thermo (w_thermo)
   );

   thermo_pattern_loader #(
      .OUT_W  (OUT_W),
      .LOAD_W (LOAD_W)
   ) u_loader (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ld_data  (ld_data),
      .i_ld_valid (ld_valid),
      .i_commit   (commit),
      .o_ld_ready (ld_ready),
      .o_pattern  (w_pattern)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt  <= '0;
         code_out   <= '0;
         dir_up     <= 1'b1;
         edge_pulse <= 1'b0;
         thermo_out <= '0;
      end else begin
         edge_pulse <= 1'b0;
         thermo_out <= (w_mode == MODE_PATTERN) ? w_pattern : w_thermo;
         if (en) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
         end
         if (w_tick) begin
            case (w_mode)
               MODE_STATIC: begin
                  code_out <= static_code;
               end
               MODE_TRIANGLE: begin
                  // Out-of-range recovery and degenerate limits take priority over turning.
                  if (!w_in_range) begin
                     code_out <= lo_lim;
                     dir_up   <= 1'b1;
                  end else if (w_degenerate) begin
                     code_out <= lo_lim;
                  end else if (dir_up) begin
                     if (w_sum >= {1'b0, hi_lim}) begin
                        code_out   <= hi_lim;
                        dir_up     <= 1'b0;
                        edge_pulse <= 1'b1;
                     end else begin
                        code_out <= w_sum[CODE_W-1:0];
                     end
                  end else begin
                     if ({1'b0, code_out} < w_lo_step) begin
                        code_out   <= lo_lim;
                        dir_up     <= 1'b1;
                        edge_pulse <= 1'b1;
                     end else begin
                        code_out <= code_out - step;
                     end
                  end
               end
               MODE_SAW: begin
                  if (!w_in_range || w_degenerate) begin
                     code_out <= lo_lim;
                  end else if (w_sum > {1'b0, hi_lim}) begin
                     code_out   <= lo_lim;
                     edge_pulse <= 1'b1;
                  end else begin
                     code_out <= w_sum[CODE_W-1:0];
                  end
               end
               default: begin
                  code_out <= code_out;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_thermo_pattern_sequencer.sv
// Scoreboard bench for thermo_pattern_sequencer: expectations queued at drive time, checked when due.
module tb_thermo_pattern_sequencer;

   localparam int unsigned CODE_W = 8;
   localparam int unsigned OUT_W  = 256;
   localparam int unsigned LOAD_W = 8;
   localparam int unsigned DIV_W  = 8;

   localparam int K_CODE = 0, K_DIR = 1, K_EDGE = 2, K_THERMO = 3,
                  K_READY = 4, K_TOP = 5, K_BOT = 6;

   logic              clk = 1'b0;
   logic              rst, en, ld_valid, ld_ready, commit;
   logic [1:0]        mode;
   logic [DIV_W-1:0]  div;
   logic [CODE_W-1:0] step, lo_lim, hi_lim, static_code, code_out;
   logic [LOAD_W-1:0] ld_data;
   logic              dir_up, edge_pulse;
   logic [OUT_W-1:0]  thermo_out;

   always #5 clk = ~clk;

   thermo_pattern_sequencer #(
      .CODE_W (CODE_W),
      .OUT_W  (OUT_W),
      .LOAD_W (LOAD_W),
      .DIV_W  (DIV_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .div         (div),
      .step        (step),
      .lo_lim      (lo_lim),
      .hi_lim      (hi_lim),
      .static_code (static_code),
      .ld_data     (ld_data),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .commit      (commit),
      .code_out    (code_out),
      .dir_up      (dir_up),
      .edge_pulse  (edge_pulse),
      .thermo_out  (thermo_out)
   );

   typedef struct {
      string        tag;
      int           kind;
      logic [255:0] exp;
      int           due;
   } sb_t;

   sb_t          sbq[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           ncyc    = 0;
   logic [255:0] tb_sh   = '0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] observe(input int kind);
      case (kind)
         K_CODE:   return 256'(code_out);
         K_DIR:    return 256'(dir_up);
         K_EDGE:   return 256'(edge_pulse);
         K_THERMO: return thermo_out;
         K_READY:  return 256'(ld_ready);
         K_TOP:    return 256'(thermo_out[255:248]);
         default:  return 256'(thermo_out[7:0]);
      endcase
   endfunction

   function automatic logic [255:0] thermo_of(input int c);
      logic [255:0] t;
      for (int i = 0; i < 256; i++) t[i] = (i < c);
      return t;
   endfunction

   task automatic expect_at(input string tag, input int kind, input logic [255:0] exp, input int lat);
      sb_t it;
      if (lat == 0) begin
         check_eq(tag, observe(kind), exp);
      end else begin
         it.tag  = tag;
         it.kind = kind;
         it.exp  = exp;
         it.due  = ncyc + lat;
         sbq.push_back(it);
      end
   endtask

   task automatic drain();
      sb_t keep[$];
      foreach (sbq[i]) begin
         if (sbq[i].due == ncyc) check_eq(sbq[i].tag, observe(sbq[i].kind), sbq[i].exp);
         else keep.push_back(sbq[i]);
      end
      sbq = keep;
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
      ncyc++;
      drain();
   endtask

   task automatic set_static(input int c);
      mode = 2'd0; static_code = CODE_W'(c); div = '0; en = 1'b1;
      cyc1();
   endtask

   task automatic beat(input logic [7:0] d);
      ld_data = d; ld_valid = 1'b1;
      tb_sh = {tb_sh[247:0], d};
      cyc1();
      ld_valid = 1'b0;
   endtask

   int tri_code[7]  = '{14, 18, 20, 16, 12, 10, 14};
   int tri_edge[7]  = '{0, 0, 1, 0, 0, 1, 0};
   int tri_dir[7]   = '{1, 1, 0, 0, 0, 1, 1};
   int saw_en[20]   = '{1,1,1,1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0, 1,1};
   int saw_code[20] = '{0,0,100,100,100,200,200,200,0,0,0,100,100, 100,100,100,100,100, 100,200};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; mode = 2'd0; div = '0; step = '0; lo_lim = '0; hi_lim = '0;
      static_code = '0; ld_data = '0; ld_valid = 1'b0; commit = 1'b0;

      // Reset and STATIC
      cyc1();
      expect_at("rst_code",   K_CODE,   '0, 1);
      expect_at("rst_dir",    K_DIR,    1,  1);
      expect_at("rst_edge",   K_EDGE,   0,  1);
      expect_at("rst_thermo", K_THERMO, '0, 1);
      expect_at("rst_ready",  K_READY,  1,  1);
      cyc1();
      rst = 1'b0; mode = 2'd0; static_code = 8'd37; div = '0; en = 1'b1;
      expect_at("static_code",   K_CODE,   37, 1);
      expect_at("static_thermo", K_THERMO, thermo_of(37), 2);
      cyc1();
      cyc1();

      // TRIANGLE lo=10 hi=20 step=4 from code 10
      set_static(10);
      mode = 2'd1; lo_lim = 8'd10; hi_lim = 8'd20; step = 8'd4;
      for (int k = 0; k < 7; k++) begin
         expect_at($sformatf("tri_code%0d", k),   K_CODE,   tri_code[k], 1);
         expect_at($sformatf("tri_edge%0d", k),   K_EDGE,   tri_edge[k], 1);
         expect_at($sformatf("tri_dir%0d", k),    K_DIR,    tri_dir[k],  1);
         expect_at($sformatf("tri_thermo%0d", k), K_THERMO, thermo_of(tri_code[k]), 2);
         cyc1();
      end

      // SAW with div=2 and an en=0 freeze mid-count
      set_static(0);
      mode = 2'd2; lo_lim = 8'd0; hi_lim = 8'd255; step = 8'd100; div = 8'd2;
      for (int k = 0; k < 20; k++) begin
         en = saw_en[k][0];
         expect_at($sformatf("saw_code%0d", k), K_CODE, saw_code[k], 1);
         expect_at($sformatf("saw_edge%0d", k), K_EDGE, (k == 8) ? 1 : 0, 1);
         cyc1();
      end

      // Boundaries: step=0 hold, lo=hi recovery, clamp at 255
      mode = 2'd1; lo_lim = 8'd0; hi_lim = 8'd255; step = 8'd0; div = '0; en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_at("step0_code", K_CODE, 200, 1);
         expect_at("step0_edge", K_EDGE, 0,   1);
         cyc1();
      end
      set_static(0);
      mode = 2'd1; lo_lim = 8'd50; hi_lim = 8'd50; step = 8'd4;
      for (int k = 0; k < 2; k++) begin
         expect_at("lohi_code", K_CODE, 50, 1);
         expect_at("lohi_edge", K_EDGE, 0,  1);
         cyc1();
      end
      set_static(1);
      mode = 2'd1; lo_lim = 8'd0; hi_lim = 8'd255; step = 8'd255;
      expect_at("clamp_code", K_CODE, 255, 1);
      expect_at("clamp_edge", K_EDGE, 1,   1);
      expect_at("clamp_dir",  K_DIR,  0,   1);
      cyc1();

      // PATTERN: full frame, overflow offer, commit
      mode = 2'd3; en = 1'b0;
      expect_at("mode_switch_thermo", K_THERMO, '0, 1);
      for (int k = 0; k < 32; k++) begin
         expect_at($sformatf("ready_beat%0d", k), K_READY, 1, 0);
         beat(8'(k));
      end
      expect_at("ready_full", K_READY, 0, 0);
      ld_data = 8'hFF; ld_valid = 1'b1;
      cyc1();
      ld_valid = 1'b0;
      expect_at("ready_still_full", K_READY, 0, 0);
      commit = 1'b1;
      expect_at("ready_after_commit", K_READY,  1,     1);
      expect_at("pat_full",           K_THERMO, tb_sh, 2);
      expect_at("pat_top_byte",       K_TOP,    8'h00, 2);
      expect_at("pat_bot_byte",       K_BOT,    8'h1F, 2);
      cyc1();
      commit = 1'b0;
      cyc1();
      cyc1();

      // Reset mid-frame discards everything
      for (int k = 0; k < 5; k++) beat(8'hC0 + 8'(k));
      rst = 1'b1;
      expect_at("midrst_thermo", K_THERMO, '0, 1);
      expect_at("midrst_ready",  K_READY,  1,  1);
      expect_at("midrst_code",   K_CODE,   '0, 1);
      expect_at("midrst_dir",    K_DIR,    1,  1);
      cyc1();
      rst = 1'b0; tb_sh = '0;
      expect_at("midrst_pattern", K_THERMO, '0, 1);
      cyc1();

      // Partial frame commit: 3 beats, upper bits zero
      beat(8'hA1); beat(8'hA2); beat(8'hA3);
      commit = 1'b1;
      expect_at("partial_commit", K_THERMO, 256'hA1A2A3, 2);
      cyc1();
      commit = 1'b0;
      cyc1();

      // Commit colliding with an accepted beat
      beat(8'h55);
      commit = 1'b1; ld_valid = 1'b1; ld_data = 8'h66;
      expect_at("collide_pattern", K_THERMO, tb_sh, 2);
      tb_sh = {tb_sh[247:0], 8'h66};
      cyc1();
      commit = 1'b0; ld_valid = 1'b0;
      for (int k = 0; k < 31; k++) begin
         expect_at($sformatf("collide_ready%0d", k), K_READY, 1, 0);
         beat(8'h10 + 8'(k));
      end
      expect_at("collide_full", K_READY, 0, 0);
      commit = 1'b1;
      expect_at("collide_frame", K_THERMO, tb_sh, 2);
      cyc1();
      commit = 1'b0;
      for (int k = 0; k < 4; k++) cyc1();

      foreach (sbq[i]) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_timeout_%s: got no sample, expected %0h", sbq[i].tag, sbq[i].exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
